// File: rtl/video_plex_out.sv
// Video plex back end: turns plex bytes into RGB555 pixels through a 256-entry palette RAM.
// Optional CPU palette readback is enabled by defining VPLEX_CRAM_READBACK_EN.
module video_plex_out #(
    parameter int CW    = 15,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stb0,
    input  logic          stb1,
    input  logic          hires,
    input  logic [3:0]    hires_pal,
    input  logic          blank,
    input  logic [7:0]    vplex_in,
    input  logic          cram_we,
    input  logic [7:0]    cram_addr,
    input  logic [CW-1:0] cram_wdata,
`ifdef VPLEX_CRAM_READBACK_EN
    input  logic          cram_re,
    input  logic [7:0]    cram_raddr,
    output logic [CW-1:0] cram_rdata,
    output logic          cram_rvld,
`endif
    output logic [CW-1:0] rgb_out,
    output logic          rgb_vld
);

    logic [CW-1:0] r_cram [DEPTH];

    logic [7:0]    r_plex;
    logic          r_blank;
    logic          r_hires;
    logic [3:0]    r_page;
    logic          r_half;
    logic          r_evt;

    logic [CW-1:0] r_cramQ;
    logic          r_blank2;
    logic          r_vld2;

    logic          w_s0;
    logic          w_s1;
    logic [7:0]    w_dispIdx;
    logic [7:0]    w_rdIdx;
    logic [CW-1:0] w_memQ;

    // stb0 wins a same-cycle collision, so the second hi-res half is simply lost then
    assign w_s0 = stb0;
    assign w_s1 = stb1 & ~stb0 & r_hires;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plex  <= '0;
            r_blank <= 1'b0;
            r_hires <= 1'b0;
            r_page  <= '0;
            r_half  <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_evt <= w_s0 | w_s1;
            if (w_s0) begin
                r_plex  <= vplex_in;
                r_blank <= blank;
                r_hires <= hires;
                r_page  <= hires_pal;
                r_half  <= 1'b0;
            end else if (w_s1) begin
                r_half  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_dispIdx = r_plex;
        if (r_hires) begin
            w_dispIdx = {r_page, (r_half ? r_plex[3:0] : r_plex[7:4])};
        end
    end

    // Palette storage is deliberately not reset; writes always land on their own edge
    always_ff @(posedge clk) begin
        if (cram_we) begin
            r_cram[cram_addr] <= cram_wdata;
        end
    end

    // Single read port sampled before the edge, so a same-edge write shows the old entry
    assign w_memQ = r_cram[w_rdIdx];

`ifdef VPLEX_CRAM_READBACK_EN
    logic       r_rdPend;
    logic [7:0] r_rdAddr;
    logic       w_rdReq;
    logic [7:0] w_cpuAddr;
    logic       w_cpuServe;

    assign w_rdReq    = r_rdPend | cram_re;
    assign w_cpuAddr  = r_rdPend ? r_rdAddr : cram_raddr;
    assign w_cpuServe = w_rdReq & ~r_evt;
    assign w_rdIdx    = r_evt ? w_dispIdx : w_cpuAddr;

    // A request arriving while one is already parked is absorbed by the parked one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPend   <= 1'b0;
            r_rdAddr   <= '0;
            cram_rdata <= '0;
            cram_rvld  <= 1'b0;
        end else begin
            r_rdPend  <= w_rdReq & r_evt;
            r_rdAddr  <= w_cpuAddr;
            cram_rvld <= w_cpuServe;
            if (w_cpuServe) begin
                cram_rdata <= w_memQ;
            end
        end
    end
`else
    assign w_rdIdx = w_dispIdx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cramQ  <= '0;
            r_blank2 <= 1'b0;
            r_vld2   <= 1'b0;
        end else begin
            r_vld2 <= r_evt;
            if (r_evt) begin
                r_cramQ  <= w_memQ;
                r_blank2 <= r_blank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
            rgb_vld <= 1'b0;
        end else begin
            rgb_vld <= r_vld2;
            if (r_vld2) begin
                rgb_out <= r_blank2 ? '0 : r_cramQ;
            end
        end
    end

endmodule

// File: tb/tb_video_plex_out.sv
// Randomised scoreboard bench for video_plex_out: a palette/pixel model predicts each
// pixel and the edge it should appear on; a monitor pops and compares on every rgb_vld.
module tb_video_plex_out;

    logic        clk;
    logic        rst_n;
    logic        stb0;
    logic        stb1;
    logic        hires;
    logic [3:0]  hires_pal;
    logic        blank;
    logic [7:0]  vplex_in;
    logic        cram_we;
    logic [7:0]  cram_addr;
    logic [14:0] cram_wdata;
    logic [14:0] rgb_out;
    logic        rgb_vld;
`ifdef VPLEX_CRAM_READBACK_EN
    logic        cram_re;
    logic [7:0]  cram_raddr;
    logic [14:0] cram_rdata;
    logic        cram_rvld;
`endif

    video_plex_out dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stb0       (stb0),
        .stb1       (stb1),
        .hires      (hires),
        .hires_pal  (hires_pal),
        .blank      (blank),
        .vplex_in   (vplex_in),
        .cram_we    (cram_we),
        .cram_addr  (cram_addr),
        .cram_wdata (cram_wdata),
`ifdef VPLEX_CRAM_READBACK_EN
        .cram_re    (cram_re),
        .cram_raddr (cram_raddr),
        .cram_rdata (cram_rdata),
        .cram_rvld  (cram_rvld),
`endif
        .rgb_out    (rgb_out),
        .rgb_vld    (rgb_vld)
    );

    typedef struct {
        logic [14:0] val;
        int          tag;
    } exp_t;

    exp_t        expQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;
    int          edgeCnt     = 0;

    logic [14:0] mMem [256];
    logic [7:0]  mPlex;
    logic        mBlank;
    logic        mHires;
    logic [3:0]  mPage;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Monitor: every pixel pulse must match the oldest prediction, in value and in edge
    always @(negedge clk) begin
        if (rst_n && rgb_vld) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL unexpected_vld: got rgb=%h at edge %0d, required no pulse", rgb_out, edgeCnt);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (rgb_out !== e.val || edgeCnt != e.tag) begin
                    nMismatched++;
                    $display("[TB] FAIL pixel: got rgb=%h at edge %0d, required %h at edge %0d",
                             rgb_out, edgeCnt, e.val, e.tag);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock of stimulus; the model predicts from the latched pixel context and the
    // palette as it stands after this edge's write (a read on the next edge sees it)
    task automatic applyStimulus(input logic s0, input logic s1, input logic hr, input logic [3:0] pal,
                                 input logic bl, input logic [7:0] px, input logic we,
                                 input logic [7:0] wa, input logic [14:0] wd);
        logic [7:0] idx;
        logic       fire;
        exp_t       e;
        stb0       = s0;
        stb1       = s1;
        cram_we    = we;
        cram_addr  = wa;
        cram_wdata = wd;
        if (s0) begin
            hires     = hr;
            hires_pal = pal;
            blank     = bl;
            vplex_in  = px;
        end
        if (we) mMem[wa] = wd;
        fire = 1'b0;
        idx  = 8'h00;
        if (s0) begin
            mPlex  = px;
            mBlank = bl;
            mHires = hr;
            mPage  = pal;
            idx    = hr ? {pal, px[7:4]} : px;
            fire   = 1'b1;
        end else if (s1 && mHires) begin
            idx  = {mPage, mPlex[3:0]};
            fire = 1'b1;
        end
        if (fire) begin
            e.val = mBlank ? 15'h0 : mMem[idx];
            e.tag = edgeCnt + 3;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        stb0    = 1'b0;
        stb1    = 1'b0;
        cram_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, 0, 8'h00, 15'h0);
    endtask

    task automatic writeCram(input logic [7:0] a, input logic [14:0] d);
        applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, 1, a, d);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL drain_timeout: %0d pixels outstanding, required 0", expQ.size());
            expQ.delete();
        end
        idle(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        stb0       = 1'b0;
        stb1       = 1'b0;
        hires      = 1'b0;
        hires_pal  = 4'h0;
        blank      = 1'b0;
        vplex_in   = 8'h00;
        cram_we    = 1'b0;
        cram_addr  = 8'h00;
        cram_wdata = 15'h0;
        mPlex      = 8'h00;
        mBlank     = 1'b0;
        mHires     = 1'b0;
        mPage      = 4'h0;
`ifdef VPLEX_CRAM_READBACK_EN
        cram_re    = 1'b0;
        cram_raddr = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rgb_out", rgb_out, 15'h0);
        checkOutput("reset_rgb_vld", {14'h0, rgb_vld}, 15'h0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 256; i++) writeCram(i[7:0], 15'($urandom));
        writeCram(8'h5A, 15'h7C00);
        writeCram(8'h3A, 15'h03E0);
        writeCram(8'h35, 15'h001F);
        writeCram(8'hFF, 15'h7FFF);
        writeCram(8'h10, 15'h1111);
        idle(3);

        $display("[TB] normal mode pixel");
        applyStimulus(1, 0, 0, 4'h0, 0, 8'h5A, 0, 8'h00, 15'h0);
        drain();
        checkOutput("t1_rgb", rgb_out, 15'h7C00);

        $display("[TB] hi-res pair");
        applyStimulus(1, 0, 1, 4'h3, 0, 8'hA5, 0, 8'h00, 15'h0);
        idle(1);
        applyStimulus(0, 1, 0, 4'h0, 0, 8'h00, 0, 8'h00, 15'h0);
        drain();
        checkOutput("t2_second_half", rgb_out, 15'h001F);

        $display("[TB] blanked hi-res pair");
        applyStimulus(1, 0, 1, 4'hF, 1, 8'hFF, 0, 8'h00, 15'h0);
        applyStimulus(0, 1, 0, 4'h0, 0, 8'h00, 0, 8'h00, 15'h0);
        drain();
        checkOutput("t3_blank", rgb_out, 15'h0);

        $display("[TB] write/read collision");
        applyStimulus(1, 0, 0, 4'h0, 0, 8'h10, 0, 8'h00, 15'h0);
        applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, 1, 8'h10, 15'h2222);
        applyStimulus(1, 0, 0, 4'h0, 0, 8'h10, 0, 8'h00, 15'h0);
        drain();
        checkOutput("t4_new_entry", rgb_out, 15'h2222);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 0, 4'h0, 0, 8'h5A, 0, 8'h00, 15'h0);
        void'(expQ.pop_back());
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rgb_out", rgb_out, 15'h0);
        checkOutput("t5_rgb_vld", {14'h0, rgb_vld}, 15'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mHires = 1'b0;
        mBlank = 1'b0;
        mPlex  = 8'h00;
        mPage  = 4'h0;
        idle(6);
        checkOutput("t5_after_release", rgb_out, 15'h0);

`ifdef VPLEX_CRAM_READBACK_EN
        begin
            int  lastStb0;
            int  seenEdge;
            $display("[TB] palette readback under traffic");
            for (int i = 0; i < 6; i++) begin
                if (i == 2) begin
                    cram_re    = 1'b1;
                    cram_raddr = 8'h10;
                end
                applyStimulus(1, 0, 0, 4'h0, 0, 8'h22, 0, 8'h00, 15'h0);
                cram_re = 1'b0;
            end
            lastStb0 = edgeCnt;
            seenEdge = -1;
            for (int i = 0; i < 10 && seenEdge < 0; i++) begin
                idle(1);
                if (cram_rvld) begin
                    seenEdge = edgeCnt;
                    checkOutput("t6_rdata", cram_rdata, 15'h2222);
                end
            end
            nCompared++;
            if (seenEdge != lastStb0 + 2) begin
                nMismatched++;
                $display("[TB] FAIL t6_timing: got rvld at edge %0d, required edge %0d", seenEdge, lastStb0 + 2);
            end
            drain();
        end
`endif

        $display("[TB] randomised traffic");
        for (int g = 0; g < 80; g++) begin
            logic       hr;
            logic [3:0] pal;
            logic       bl;
            logic [7:0] px;
            logic       coll;
            hr   = 1'($urandom);
            pal  = 4'($urandom);
            bl   = ($urandom_range(0, 4) == 0);
            px   = 8'($urandom);
            coll = ($urandom_range(0, 7) == 0);
            applyStimulus(1, coll, hr, pal, bl, px, ($urandom_range(0, 3) == 0), 8'($urandom), 15'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 1)); k++)
                applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, ($urandom_range(0, 3) == 0), 8'($urandom), 15'($urandom));
            if (hr || ($urandom_range(0, 3) == 0))
                applyStimulus(0, 1, 0, 4'h0, 0, 8'h00, ($urandom_range(0, 3) == 0), 8'($urandom), 15'($urandom));
            if ($urandom_range(0, 1) == 0) idle(1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
